rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 The block SHALL take `ROB_SZ` (default 8, power of two, entry count) from sys_defs.
REQ-002 The block SHALL take `XLEN` (default 32, data/PC width) from sys_defs.
REQ-003 The block SHALL define IDX as $clog2(`ROB_SZ), the ROB index width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high. Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: synchronous, active-high.
REQ-005 The block SHALL have these dispatch ports:
- dispatch_valid, input, 1: allocate request.
- dispatch_dest_reg, input, 5: architectural destination.
- dispatch_NPC, input, XLEN: next PC.
- dispatch_halt, input, 1: WFI instruction.
- dispatch_illegal, input, 1: illegal instruction.
- dispatch_ready, output, 1: allocation is possible this cycle.
- dispatch_rob_index, output, IDX: index assigned to the request (the current tail).
REQ-006 The block SHALL have these completion ports:
- complete_valid, input, 1: completion strobe.
- complete_rob_index, input, IDX: entry that completed.
REQ-007 The block SHALL have these retire ports:
- rob_head, output, IDX: oldest entry index.
- head_valid, output, 1: head entry is occupied and completed.
- head_entry, output, ROB_ENTRY: head contents.
- move_head, input, 1: retire consumed the head.
REQ-008 The block SHALL have these control ports:
- squash, input, 1: flush all entries.
- rob_count, output, IDX+1: occupancy.

Function
REQ-009 Each entry SHALL hold valid, completed, dest_reg, NPC, halt and illegal.
REQ-010 A dispatch SHALL be accepted when dispatch_valid && dispatch_ready.
- On acceptance, the entry at tail SHALL be written with valid=1, completed=0 and the dispatch fields.
- Tail SHALL then advance mod `ROB_SZ`.
REQ-011 dispatch_rob_index SHALL equal the tail combinationally, whether or not the request is accepted.
REQ-012 complete_valid SHALL set completed=1 on the indexed entry at the next edge, only if that entry is valid; completion of an invalid entry SHALL be ignored.
REQ-013 head_valid SHALL equal entry[head].valid && entry[head].completed, combinationally.
- Consequence: a completion is visible on head_valid one cycle after complete_valid.
REQ-014 When move_head && head_valid, the head entry SHALL be invalidated and head SHALL advance mod `ROB_SZ`; move_head while !head_valid SHALL be ignored.
REQ-015 rob_count SHALL track occupancy:
- +1 per accepted dispatch, -1 per accepted retire, unchanged when both occur in one cycle.
- Range 0..`ROB_SZ`.
- Full: count==`ROB_SZ`. Empty: count==0.
REQ-016 head and tail SHALL wrap from `ROB_SZ`-1 to 0 with no stall.
REQ-017 Completion of entry X and retire of entry X in the same cycle SHALL clear X; the completion SHALL be discarded.
REQ-018 Squash SHALL dominate:
- Next cycle: all valid=0, head=tail=0, count=0.
- Dispatch, completion and move_head in the squash cycle SHALL have no effect.
- dispatch_ready SHALL be 0 while squash is high.

Reset
REQ-019 While reset is high at a clock edge, the block SHALL set head=tail=0, count=0 and all valid/completed=0.
REQ-020 The block SHALL hold dispatch_ready=0 while reset is high.
REQ-021 After reset, the block SHALL drive rob_head=0, head_valid=0, rob_count=0, dispatch_rob_index=0, dispatch_ready=1.
REQ-022 Reset asserted mid-operation SHALL discard all entries, identically to squash.

Configuration
REQ-023 The block SHALL implement macro ROB_FULL_BYPASS_EN as follows:
- Defined: dispatch_ready = !squash && (!full || (move_head && head_valid)), so a full ROB accepts a dispatch into the slot freed the same cycle.
- Undefined: dispatch_ready = !squash && !full, with no combinational path from move_head.

Structure
REQ-024 ROB_ENTRY (valid, completed, dest_reg[4:0], NPC[`XLEN-1:0], halt, illegal) SHALL be declared in the shared sys_defs package, alongside `ROB_SZ`.
REQ-025 The block SHALL be a single module with no sub-module; pointer increment and wrap SHALL be inline.

Verification (ROB_SZ=8)
REQ-026 Reset, then dispatch 3 -> indices 0,1,2; rob_count=3; head_valid=0.
REQ-027 Complete index 1, then index 0 -> head_valid rises one cycle after index 0 completes; move_head retires 0 then 1; rob_head=2.
REQ-028 Dispatch 8 with no retire -> dispatch_ready=0 and rob_count=8; a 9th request is not accepted and the tail is unchanged.
REQ-029 Fill, then complete head and assert move_head with dispatch_valid:
- With the macro defined -> dispatch accepted at index 0, count stays 8.
- Without it -> the dispatch is rejected.
REQ-030 Run 20 dispatch/complete/retire cycles -> indices wrap 7->0; retire order equals dispatch order.
REQ-031 Squash with 5 entries plus concurrent dispatch/complete/move_head -> next cycle count=0, rob_head=0, dispatch_rob_index=0, head_valid=0.

Source files
------------

// File: rtl/sys_defs.sv
// Shared definitions for the reorder buffer: sizing macros and the ROB entry layout.
`ifndef ROB_SZ
`define ROB_SZ 8
`endif
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

  typedef struct packed {
    logic              valid;
    logic              completed;
    logic [4:0]        dest_reg;
    logic [`XLEN-1:0]  NPC;
    logic              halt;
    logic              illegal;
  } ROB_ENTRY;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocate/retire ring with out-of-order completion.
// Optional macro ROB_FULL_BYPASS_EN lets a full ROB accept a dispatch into the slot retired that cycle.
`ifndef ROB_SZ
`define ROB_SZ 8
`endif
`ifndef XLEN
`define XLEN 32
`endif

module rob
  import sys_defs::*;
#(
  localparam int unsigned IDX = $clog2(`ROB_SZ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dispatch_valid,
  input  logic [4:0]       dispatch_dest_reg,
  input  logic [`XLEN-1:0] dispatch_NPC,
  input  logic             dispatch_halt,
  input  logic             dispatch_illegal,
  output logic             dispatch_ready,
  output logic [IDX-1:0]   dispatch_rob_index,
  input  logic             complete_valid,
  input  logic [IDX-1:0]   complete_rob_index,
  output logic [IDX-1:0]   rob_head,
  output logic             head_valid,
  output ROB_ENTRY         head_entry,
  input  logic             move_head,
  input  logic             squash,
  output logic [IDX:0]     rob_count
);

  ROB_ENTRY       entries_q [`ROB_SZ];
  ROB_ENTRY       entries_d [`ROB_SZ];
  logic [IDX-1:0] head_q, head_d;
  logic [IDX-1:0] tail_q, tail_d;
  logic [IDX:0]   count_q, count_d;

  logic full;
  logic retire;
  logic accept;

  assign full       = (count_q == (IDX+1)'(`ROB_SZ));
  assign head_valid = entries_q[head_q].valid && entries_q[head_q].completed;
  assign retire     = move_head && head_valid;

`ifdef ROB_FULL_BYPASS_EN
  assign dispatch_ready = !reset && !squash && (!full || retire);
`else
  assign dispatch_ready = !reset && !squash && !full;
`endif

  assign accept             = dispatch_valid && dispatch_ready;
  assign dispatch_rob_index = tail_q;
  assign rob_head           = head_q;
  assign head_entry         = entries_q[head_q];
  assign rob_count          = count_q;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (reset || squash) begin
      for (int unsigned i = 0; i < `ROB_SZ; i++) begin
        entries_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (complete_valid && entries_q[complete_rob_index].valid) begin
        entries_d[complete_rob_index].completed = 1'b1;
      end
      // Retire clears after completion so a same-cycle completion of the head is dropped;
      // dispatch writes last so a bypassed allocation into the freed slot survives.
      if (retire) begin
        entries_d[head_q] = '0;
        head_d            = head_q + 1'b1;
      end
      if (accept) begin
        entries_d[tail_q].valid     = 1'b1;
        entries_d[tail_q].completed = 1'b0;
        entries_d[tail_q].dest_reg  = dispatch_dest_reg;
        entries_d[tail_q].NPC       = dispatch_NPC;
        entries_d[tail_q].halt      = dispatch_halt;
        entries_d[tail_q].illegal   = dispatch_illegal;
        tail_d                      = tail_q + 1'b1;
      end
      case ({accept, retire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    entries_q <= entries_d;
    head_q    <= head_d;
    tail_q    <= tail_d;
    count_q   <= count_d;
  end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: dispatched entries are queued and compared in order at retire.
`ifndef ROB_SZ
`define ROB_SZ 8
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_rob;
  import sys_defs::*;

  localparam int unsigned IDX = $clog2(`ROB_SZ);
  localparam int unsigned SZ  = `ROB_SZ;

  logic             clock = 1'b0;
  logic             reset;
  logic             dispatch_valid;
  logic [4:0]       dispatch_dest_reg;
  logic [`XLEN-1:0] dispatch_NPC;
  logic             dispatch_halt;
  logic             dispatch_illegal;
  logic             dispatch_ready;
  logic [IDX-1:0]   dispatch_rob_index;
  logic             complete_valid;
  logic [IDX-1:0]   complete_rob_index;
  logic [IDX-1:0]   rob_head;
  logic             head_valid;
  ROB_ENTRY         head_entry;
  logic             move_head;
  logic             squash;
  logic [IDX:0]     rob_count;

  rob dut (
    .clock              (clock),
    .reset              (reset),
    .dispatch_valid     (dispatch_valid),
    .dispatch_dest_reg  (dispatch_dest_reg),
    .dispatch_NPC       (dispatch_NPC),
    .dispatch_halt      (dispatch_halt),
    .dispatch_illegal   (dispatch_illegal),
    .dispatch_ready     (dispatch_ready),
    .dispatch_rob_index (dispatch_rob_index),
    .complete_valid     (complete_valid),
    .complete_rob_index (complete_rob_index),
    .rob_head           (rob_head),
    .head_valid         (head_valid),
    .head_entry         (head_entry),
    .move_head          (move_head),
    .squash             (squash),
    .rob_count          (rob_count)
  );

  always #5 clock = ~clock;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned m_head = 0;
  int unsigned m_tail = 0;
  int unsigned m_count = 0;
  logic [63:0] sb [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    m_head = 0;
    m_tail = 0;
    m_count = 0;
    sb.delete();
  endtask

  task automatic do_dispatch(input logic [4:0] d, input logic [`XLEN-1:0] npc,
                             input logic h, input logic il);
    dispatch_valid    = 1'b1;
    dispatch_dest_reg = d;
    dispatch_NPC      = npc;
    dispatch_halt     = h;
    dispatch_illegal  = il;
    #1;
    check("disp_idx", 64'(dispatch_rob_index), 64'(m_tail));
    check("disp_ready", 64'(dispatch_ready), 64'd1);
    tick();
    dispatch_valid = 1'b0;
    sb.push_back({25'd0, h, il, d, npc});
    m_tail = (m_tail + 1) % SZ;
    m_count++;
    check("disp_count", 64'(rob_count), 64'(m_count));
  endtask

  task automatic do_complete(input int unsigned idx);
    complete_valid     = 1'b1;
    complete_rob_index = IDX'(idx);
    tick();
    complete_valid = 1'b0;
  endtask

  task automatic do_retire();
    logic [63:0] exp;
    move_head = 1'b1;
    #1;
    check("ret_head_valid", 64'(head_valid), 64'd1);
    check("ret_head_idx", 64'(rob_head), 64'(m_head));
    check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 64'd0;
    check("ret_entry", {25'd0, head_entry.halt, head_entry.illegal,
                        head_entry.dest_reg, head_entry.NPC}, exp);
    tick();
    move_head = 1'b0;
    m_head = (m_head + 1) % SZ;
    m_count--;
    check("ret_count", 64'(rob_count), 64'(m_count));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; squash = 1'b0; move_head = 1'b0;
    dispatch_valid = 1'b0; dispatch_dest_reg = '0; dispatch_NPC = '0;
    dispatch_halt = 1'b0; dispatch_illegal = 1'b0;
    complete_valid = 1'b0; complete_rob_index = '0;
    tick();
    tick();
    check("rst_ready_low", 64'(dispatch_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_head", 64'(rob_head), 64'd0);
    check("rst_head_valid", 64'(head_valid), 64'd0);
    check("rst_count", 64'(rob_count), 64'd0);
    check("rst_tail", 64'(dispatch_rob_index), 64'd0);
    check("rst_ready", 64'(dispatch_ready), 64'd1);

    // Three dispatches, out-of-order completion, in-order retire
    for (int i = 0; i < 3; i++) do_dispatch(5'(i + 1), 32'h1000 + 32'(4 * i), 1'b0, 1'(i == 2));
    check("three_head_valid", 64'(head_valid), 64'd0);
    do_complete(1);
    check("c1_head_valid", 64'(head_valid), 64'd0);
    do_complete(0);
    check("c0_head_valid", 64'(head_valid), 64'd1);
    do_retire();
    do_retire();
    check("head_after2", 64'(rob_head), 64'd2);

    // Squash with 5 entries and concurrent activity
    for (int i = 0; i < 4; i++) do_dispatch(5'(10 + i), 32'h2000 + 32'(i), 1'b1, 1'b0);
    check("pre_squash_count", 64'(rob_count), 64'd5);
    do_complete(2);
    squash = 1'b1; dispatch_valid = 1'b1; complete_valid = 1'b1;
    complete_rob_index = IDX'(3); move_head = 1'b1;
    #1;
    check("squash_ready", 64'(dispatch_ready), 64'd0);
    tick();
    squash = 1'b0; dispatch_valid = 1'b0; complete_valid = 1'b0; move_head = 1'b0;
    #1;
    model_clear();
    check("sq_count", 64'(rob_count), 64'd0);
    check("sq_head", 64'(rob_head), 64'd0);
    check("sq_tail", 64'(dispatch_rob_index), 64'd0);
    check("sq_head_valid", 64'(head_valid), 64'd0);

    // Completion of an invalid entry is ignored
    do_complete(0);
    do_dispatch(5'd7, 32'h3000, 1'b0, 1'b0);
    check("invalid_complete", 64'(head_valid), 64'd0);
    for (int i = 1; i < 8; i++) do_dispatch(5'(20 + i), 32'h3000 + 32'(i), 1'(i[0]), 1'(i[1]));
    check("full_count", 64'(rob_count), 64'd8);
    check("full_ready", 64'(dispatch_ready), 64'd0);
    dispatch_valid = 1'b1; dispatch_dest_reg = 5'd31; dispatch_NPC = 32'hDEAD;
    tick();
    dispatch_valid = 1'b0;
    check("ninth_tail", 64'(dispatch_rob_index), 64'd0);
    check("ninth_count", 64'(rob_count), 64'd8);

    // Full ROB: retire head and dispatch in the same cycle
    do_complete(0);
    dispatch_valid = 1'b1; dispatch_dest_reg = 5'd30; dispatch_NPC = 32'h4000;
    dispatch_halt = 1'b1; dispatch_illegal = 1'b1;
`ifdef ROB_FULL_BYPASS_EN
    #1;
    check("byp_ready", 64'(dispatch_ready), 64'd1);
    check("byp_idx", 64'(dispatch_rob_index), 64'd0);
    sb.push_back({25'd0, 1'b1, 1'b1, 5'd30, 32'h4000});
    m_tail = 1; m_count++;
`endif
    do_retire();
    dispatch_valid = 1'b0; dispatch_halt = 1'b0; dispatch_illegal = 1'b0;
`ifdef ROB_FULL_BYPASS_EN
    check("byp_count", 64'(rob_count), 64'd8);
`else
    check("nobyp_count", 64'(rob_count), 64'd7);
`endif
    while (m_count > 0) begin
      do_complete(m_head);
      do_retire();
    end

    // Pipelined dispatch/complete/retire across the wrap point
    for (int i = 0; i < 20; i++) begin
      int unsigned t;
      t = m_tail;
      do_dispatch(5'($urandom_range(31)), $urandom, 1'b0, 1'b0);
      do_complete(t);
      do_retire();
    end
    check("wrap_empty", 64'(rob_count), 64'd0);

    // Mid-operation reset discards everything
    do_dispatch(5'd3, 32'h5000, 1'b0, 1'b0);
    do_dispatch(5'd4, 32'h5004, 1'b0, 1'b0);
    do_complete(m_head);
    reset = 1'b1;
    #1;
    check("midrst_ready", 64'(dispatch_ready), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    model_clear();
    check("midrst_count", 64'(rob_count), 64'd0);
    check("midrst_head", 64'(rob_head), 64'd0);
    check("midrst_tail", 64'(dispatch_rob_index), 64'd0);
    check("midrst_head_valid", 64'(head_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
